// File: rtl/leaky_relu_derivative_ctrl.sv
// Leaky-ReLU derivative controller: H cache, leak register and systolic lane sequencing.
// Latency: a gradient row accepted at edge t reaches lane i during cycle t+1+i.
// Backpressure: grad_ready stays high in RUN until the batch row count is reached.
// Optional feature macro: LR_D_CTRL_STALL_CNT_EN adds the stall_count output.
module leaky_relu_derivative_ctrl #(
  parameter int                 LANES      = 4,
  parameter int                 DEPTH      = 16,
  parameter logic signed [15:0] LEAK_RESET = 16'sh0003
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  input  logic signed [15:0]         cfg_leak_factor,
  input  logic                       h_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   h_wr_addr,
  input  logic [16*LANES-1:0]        h_wr_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_rows,
  input  logic                       grad_valid,
  input  logic [16*LANES-1:0]        grad_data,
  output logic                       grad_ready,
  output logic [LANES-1:0]           lane_valid,
  output logic [16*LANES-1:0]        lane_data,
  output logic [16*LANES-1:0]        lane_H_data,
  output logic signed [15:0]         lane_leak_factor,
  input  logic [LANES-1:0]           child_valid_out,
  output logic                       busy,
  output logic                       done
`ifdef LR_D_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]                stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      rows;
  logic [CW-1:0]      issued;
  logic [CW-1:0]      completed;
  logic [CW-1:0]      eff_rows;
  logic signed [15:0] leak;
  logic [16*LANES-1:0] h_mem [DEPTH];
  logic [16*LANES-1:0] h_rd;
  logic               accept;
  logic               idle_start;

  // Only the last lane's return marks row completion; the others are not needed here.
  logic unused_child;
  assign unused_child = ^child_valid_out;

  assign eff_rows   = (num_rows > CW'(DEPTH)) ? CW'(DEPTH) : num_rows;
  assign idle_start = (state == IDLE) && start;
  assign accept     = grad_valid && grad_ready;
  assign h_rd       = h_mem[issued[AW-1:0]];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (eff_rows == '0) ? DONE : RUN;
      RUN:   if (accept && (issued + CW'(1) == rows)) state_nxt = DRAIN;
      DRAIN: if (completed == rows) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    grad_ready = 1'b0;
    case (state)
      RUN: begin
        busy       = 1'b1;
        grad_ready = (issued < rows);
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Leak factor register; only writable between batches so a batch sees one value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             leak <= LEAK_RESET;
    else if (state == IDLE && cfg_valid)  leak <= cfg_leak_factor;
  end

  assign lane_leak_factor = leak;

  // H cache; frozen outside IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) h_mem[r] <= '0;
    end else if (state == IDLE && h_wr_en) begin
      h_mem[h_wr_addr] <= h_wr_data;
    end
  end

  // Batch row count, issue counter and completion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows      <= '0;
      issued    <= '0;
      completed <= '0;
    end else if (idle_start) begin
      rows      <= eff_rows;
      issued    <= '0;
      completed <= '0;
    end else begin
      if (accept) issued <= issued + CW'(1);
      if ((state == RUN || state == DRAIN) && child_valid_out[LANES-1])
        completed <= completed + CW'(1);
    end
  end

  // Per-lane delay lines: lane i sees the row i+1 cycles after acceptance.
  // Idle slots carry zero data so lanes never see stale values.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0]  v_sr;
    logic [15:0] g_sr [i+1];
    logic [15:0] h_sr [i+1];

    // Shift the lane's valid, gradient and H slice by one stage per cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_sr <= '0;
        for (int j = 0; j <= i; j++) begin
          g_sr[j] <= '0;
          h_sr[j] <= '0;
        end
      end else begin
        v_sr[0] <= accept;
        g_sr[0] <= accept ? grad_data[16*i +: 16] : 16'h0000;
        h_sr[0] <= accept ? h_rd[16*i +: 16]      : 16'h0000;
        for (int j = 1; j <= i; j++) begin
          v_sr[j] <= v_sr[j-1];
          g_sr[j] <= g_sr[j-1];
          h_sr[j] <= h_sr[j-1];
        end
      end
    end

    assign lane_valid[i]            = v_sr[i];
    assign lane_data[16*i +: 16]    = g_sr[i];
    assign lane_H_data[16*i +: 16]  = h_sr[i];
  end

`ifdef LR_D_CTRL_STALL_CNT_EN
  // Count RUN cycles where the controller was ready but no gradient was offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_count <= '0;
    else if (idle_start)
      stall_count <= '0;
    else if (grad_ready && !grad_valid && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_leaky_relu_derivative_ctrl.sv
// Directed bench for leaky_relu_derivative_ctrl with a one-cycle child return model.
module tb_leaky_relu_derivative_ctrl;
  localparam int LANES = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [15:0] cfg_leak_factor;
  logic        h_wr_en;
  logic [3:0]  h_wr_addr;
  logic [63:0] h_wr_data;
  logic        start;
  logic [4:0]  num_rows;
  logic        grad_valid;
  logic [63:0] grad_data;
  logic        grad_ready;
  logic [3:0]  lane_valid;
  logic [63:0] lane_data;
  logic [63:0] lane_H_data;
  logic [15:0] lane_leak_factor;
  logic [3:0]  child_valid_out;
  logic        busy;
  logic        done;
`ifdef LR_D_CTRL_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  leaky_relu_derivative_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .LEAK_RESET(16'sh0003)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_leak_factor(cfg_leak_factor),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .start(start), .num_rows(num_rows),
    .grad_valid(grad_valid), .grad_data(grad_data), .grad_ready(grad_ready),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_H_data(lane_H_data),
    .lane_leak_factor(lane_leak_factor), .child_valid_out(child_valid_out),
    .busy(busy), .done(done)
`ifdef LR_D_CTRL_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Child lanes answer one cycle after their beat.
  always @(posedge clk or negedge rst) begin
    if (!rst) child_valid_out <= '0;
    else      child_valid_out <= lane_valid;
  end

  int          checks = 0;
  int          errors = 0;
  logic [63:0] h_mem [DEPTH];
  logic [15:0] leak_exp;
  int          hist [LANES];
  bit          acc_pending;
  int          pend_row;

  function automatic logic [63:0] gfun(input int k);
    return {16'hC000 + 16'(k), 16'h3000 + 16'(k), 16'h2000 + 16'(k), 16'h1000 + 16'(k)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_lanes();
    logic [63:0] ge;
    logic [63:0] he;
    bit v;
    for (int i = 0; i < LANES; i++) begin
      v  = (hist[i] >= 0);
      ge = v ? gfun(hist[i]) : 64'h0;
      he = v ? h_mem[hist[i]] : 64'h0;
      chk($sformatf("lane%0d_valid", i), 64'(lane_valid[i]), 64'(v));
      chk($sformatf("lane%0d_data", i), 64'(lane_data[16*i +: 16]), 64'(ge[16*i +: 16]));
      chk($sformatf("lane%0d_H", i), 64'(lane_H_data[16*i +: 16]), 64'(he[16*i +: 16]));
    end
    chk("leak", 64'(lane_leak_factor), 64'(leak_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = LANES - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = acc_pending ? pend_row : -1;
    acc_pending = 1'b0;
    check_lanes();
  endtask

  task automatic wr_h(input int a, input logic [63:0] d);
    h_wr_en = 1'b1; h_wr_addr = 4'(a); h_wr_data = d;
    h_mem[a] = d;
    tick();
    h_wr_en = 1'b0;
  endtask

  task automatic load_leak(input logic [15:0] v);
    cfg_valid = 1'b1; cfg_leak_factor = v;
    leak_exp = v;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run_batch(input int n, input int exp_rows, input bit bp, input bit disturb);
    int issued = 0;
    int cyc = 0;
    int last_acc = 0;
    int child_seen = 0;
    bit seen = 0;
    logic [4:0] pat = 5'b11001;
    num_rows = 5'(n); start = 1'b1;
    tick();
    start = 1'b0;
    if (exp_rows == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_ready", 64'(grad_ready), 64'd0);
      chk("zero_busy", 64'(busy), 64'd0);
      tick();
      chk("zero_done_clr", 64'(done), 64'd0);
      chk("zero_ready2", 64'(grad_ready), 64'd0);
      return;
    end
    chk("busy_run", 64'(busy), 64'd1);
    if (disturb) begin
      cfg_valid = 1'b1; cfg_leak_factor = 16'h0010;
      h_wr_en = 1'b1; h_wr_addr = 4'd1; h_wr_data = 64'hDEAD_BEEF_0BAD_F00D;
    end
    while (!seen && cyc < 200) begin
      grad_valid = (bp && cyc < 5) ? pat[cyc] : 1'b1;
      grad_data  = gfun(issued);
      chk("grad_ready", 64'(grad_ready), 64'(issued < exp_rows));
      if (grad_valid && issued < exp_rows) begin
        acc_pending = 1'b1; pend_row = issued; issued++; last_acc = cyc;
      end
      tick();
      cyc++;
      if (child_valid_out[3]) child_seen++;
      if (done) begin
        seen = 1'b1;
        chk("done_latency", 64'(cyc - last_acc), 64'd7);
        chk("child_returns", 64'(child_seen), 64'(exp_rows));
      end else begin
        chk("busy_hold", 64'(busy), 64'd1);
      end
    end
    grad_valid = 1'b0; cfg_valid = 1'b0; h_wr_en = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("accepts", 64'(issued), 64'(exp_rows));
    tick();
    chk("done_pulse_end", 64'(done), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("ready_end", 64'(grad_ready), 64'd0);
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 0; cfg_leak_factor = 0; h_wr_en = 0; h_wr_addr = 0; h_wr_data = 0;
    start = 0; num_rows = 0; grad_valid = 0; grad_data = 0;
    acc_pending = 0; pend_row = 0; leak_exp = 16'h0003;
    for (int i = 0; i < LANES; i++) hist[i] = -1;
    for (int r = 0; r < DEPTH; r++) h_mem[r] = 64'h0;

    // Reset state
    #12;
    check_lanes();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(grad_ready), 64'd0);
    rst = 1'b1;
    tick();

    // 1: basic batch of 3 rows, gradient always offered
    load_leak(16'h0003);
    for (int r = 0; r < 3; r++) wr_h(r, {16'hFC00, 16'h0300, 16'hFE00, 16'h0100});
    run_batch(3, 3, 1'b0, 1'b0);

    // 2: backpressure pattern 1,0,0,1,1
    run_batch(3, 3, 1'b1, 1'b0);
`ifdef LR_D_CTRL_STALL_CNT_EN
    chk("stall_count", 64'(stall_count), 64'd2);
`endif

    // 3: empty batch
    run_batch(0, 0, 1'b0, 1'b0);

    // 4: oversize batch clamps to DEPTH
    for (int r = 0; r < DEPTH; r++) wr_h(r, {8'(r), 8'h44, 8'(r), 8'h33, 8'(r), 8'h22, 8'(r), 8'h11});
    run_batch(20, 16, 1'b0, 1'b0);

    // 5: config and H writes during a batch are ignored, then honoured in IDLE
    run_batch(3, 3, 1'b0, 1'b1);
    load_leak(16'h0010);
    chk("leak_loaded", 64'(lane_leak_factor), 64'h0010);

    // 6: reset during DRAIN aborts the batch
    num_rows = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    grad_valid = 1'b1; grad_data = gfun(0); acc_pending = 1'b1; pend_row = 0;
    tick();
    grad_data = gfun(1); acc_pending = 1'b1; pend_row = 1;
    tick();
    grad_valid = 1'b0;
    tick();
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_lane_active", 64'(lane_valid != 4'b0000), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < LANES; i++) hist[i] = -1;
    for (int r = 0; r < DEPTH; r++) h_mem[r] = 64'h0;
    leak_exp = 16'h0003;
    check_lanes();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("no_done_after_abort", 64'(done), 64'd0);
    end
    wr_h(0, 64'h0102_0304_0506_0708);
    wr_h(1, 64'hF1F2_F3F4_F5F6_F7F8);
    run_batch(2, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/leaky_relu_derivative_ctrl.md
Name: leaky_relu_derivative_ctrl

Overview:
- Sequences one backward-pass batch through a row of LANES leaky-ReLU-derivative child lanes.
- Holds the forward-pass H cache and the leak-factor configuration register.
- Accepts gradient rows over a valid/ready handshake and drives each lane with its gradient, cached H and leak factor, skewed one cycle per lane (systolic order).
- Counts completed rows at the last lane and pulses done.

Parameters:
LANES, 4, number of child lanes (16-bit each)
DEPTH, 16, rows held in the H cache
LEAK_RESET, 16'sh0003, leak-factor value after reset (Q8.8, ~0.01)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (asserted at 0)
cfg_valid  in  1  load cfg_leak_factor (honoured in IDLE only)
cfg_leak_factor  in  16  signed leak factor
h_wr_en  in  1  write H row (honoured in IDLE only)
h_wr_addr  in  $clog2(DEPTH)  H row address
h_wr_data  in  16*LANES  H row, lane i at [16i+15:16i]
start  in  1  begin batch (IDLE only)
num_rows  in  $clog2(DEPTH)+1  rows in batch, sampled on start
grad_valid  in  1  gradient row valid
grad_data  in  16*LANES  gradient row
grad_ready  out  1  controller accepts gradient row
lane_valid  out  LANES  per-lane valid to children
lane_data  out  16*LANES  per-lane gradient
lane_H_data  out  16*LANES  per-lane cached H
lane_leak_factor  out  16  broadcast leak factor
child_valid_out  in  LANES  valid outputs returned from children
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - all outputs 0, except lane_leak_factor = LEAK_RESET.
  - H cache rows = 0; row and completion counters = 0; state = IDLE.
- Reset is asynchronous and active-low. Asserting it mid-batch aborts the batch: no done pulse, all skew registers are cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cfg_valid loads the leak register; the new value is visible on lane_leak_factor the next cycle.
  - h_wr_en writes H[h_wr_addr] on the clock edge.
  - start latches rows = min(num_rows, DEPTH) and clears the counters.
  - start with rows == 0 goes straight to DONE.
  - start, cfg_valid and h_wr_en in the same cycle: the writes complete first, and the batch uses the new values.
- RUN:
  - grad_ready = (issued < rows).
  - A transfer occurs when grad_valid && grad_ready. The controller reads H[issued] combinationally and increments issued.
  - When issued reaches rows, the controller moves to DRAIN.
  - grad_valid while grad_ready = 0 is ignored: the gradient row is not consumed.
- Skew:
  - A row accepted at edge t drives lane i (lane_valid[i], lane_data slice, lane_H_data slice) during cycle t+1+i.
  - lane_valid[i] is 0 and the data slices are 0 on cycles with no row for that lane.
  - Back-to-back accepts produce back-to-back lane beats with no bubbles.
- Completion:
  - completed increments on child_valid_out[LANES-1].
  - In DRAIN, when completed == rows, the controller moves to DONE.
  - Expected: the last lane's child output arrives 1 cycle after its lane beat, i.e. LANES+1 cycles after the last accept.
- DONE: done = 1 for exactly one cycle, then IDLE.
- busy = 1 in RUN and DRAIN.
- In RUN, DRAIN and DONE, start, cfg_valid and h_wr_en are ignored. The leak factor and H cache are frozen for the batch.
- No arithmetic is done here; data is passed through unmodified, signed 16-bit.

Optional Feature:
- Macro: LR_D_CTRL_STALL_CNT_EN.
- When defined:
  - adds output stall_count (16 bits).
  - stall_count increments each RUN cycle with grad_ready && !grad_valid, and saturates at 16'hFFFF.
  - It clears on start and on reset.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
1. Reset release, cfg_valid with 16'sh0003 → lane_leak_factor = 16'sh0003; write H rows 0..2 = {+1, −2, +3, −4} (Q8.8), start with num_rows = 3, grad_valid held high:
   - grad_ready high for 3 accepts, then low;
   - lane i shows row r at cycle accept_r+1+i;
   - done pulses once after child_valid_out[3] has been seen 3 times.
2. Backpressure: grad_valid toggles 1,0,0,1,1 with num_rows = 3:
   - exactly 3 transfers occur;
   - lane beats carry gaps matching the idle cycles;
   - with LR_D_CTRL_STALL_CNT_EN defined, stall_count = 2.
3. num_rows = 0 → done pulses 1 cycle after start, grad_ready never rises.
4. num_rows = 20 with DEPTH = 16 → exactly 16 rows accepted; row 15 uses H[15].
5. cfg_valid = 16'sh0010 and h_wr_en asserted during RUN → lane_leak_factor and H are unchanged for the batch; after done, the same cfg_valid loads 16'sh0010.
6. rst driven low during DRAIN → all lane_valid = 0, busy = 0 immediately, no done pulse; the next batch runs normally.
